// File: rtl/cga_vram_arbiter_if.sv
// cga_vram_arbiter_if
// Bundles the ISA host port, the CRTC pixel-fetch port and the VRAM macro
// port of the CGA VRAM arbiter. The arbiter connects through the slave
// modport; the master modport is the view of the surrounding logic.
interface cga_vram_arbiter_if #(
    parameter int ADDR_W = 14
);
    // ISA host side
    logic [18:0]       isa_addr;
    logic [7:0]        isa_din;
    logic              isa_read;
    logic              isa_write;
    logic              isa_op_enable;
    logic [7:0]        isa_dout;
    logic              isa_ready;
    logic              isa_starve;
    // CRTC pixel fetch side
    logic              pixel_req;
    logic [18:0]       pixel_addr;
    logic [7:0]        pixel_data;
    logic              pixel_valid;
    // VRAM macro side
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_dout;

    modport slave (
        input  isa_addr, isa_din, isa_read, isa_write, isa_op_enable,
        output isa_dout, isa_ready, isa_starve,
        input  pixel_req, pixel_addr,
        output pixel_data, pixel_valid,
        output mem_addr, mem_din, mem_we, mem_re,
        input  mem_dout
    );

    modport master (
        output isa_addr, isa_din, isa_read, isa_write, isa_op_enable,
        input  isa_dout, isa_ready, isa_starve,
        output pixel_req, pixel_addr,
        input  pixel_data, pixel_valid,
        input  mem_addr, mem_din, mem_we, mem_re,
        output mem_dout
    );
endinterface

// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter
// Time-shares one single-port CGA VRAM between the ISA host (read/write,
// stalled via isa_ready) and the CRTC pixel fetcher (read only, fixed
// 3-cycle latency). By default the pixel fetcher always wins the slot.
// Optional build macro CGA_SNOW_EN: the ISA access wins instead; the
// displaced pixel still completes on time but carries the ISA byte (snow).
module cga_vram_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int MAX_ISA_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    cga_vram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_ISA_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_ISA_WAIT);

    typedef enum logic [2:0] {
        ISA_IDLE = 3'd0,   // no access in progress
        ISA_PEND = 3'd1,   // access latched, waiting for a slot
        ISA_RD1  = 3'd2,   // read issued, mem_re on the VRAM port
        ISA_RD2  = 3'd3,   // read data on mem_dout
        ISA_DONE = 3'd4    // access complete, waiting for strobe to drop
    } isa_state_t;

    isa_state_t        state_r;
    isa_state_t        state_s;

    logic              strb_s;
    logic              strb_prev_r;
    logic              start_s;

    logic [ADDR_W-1:0] lat_addr_r;
    logic [7:0]        lat_din_r;
    logic              lat_wr_r;
    logic [ADDR_W-1:0] req_addr_s;
    logic [7:0]        req_din_s;
    logic              req_wr_s;

    logic              isa_want_s;
    logic              isa_slot_s;
    logic              pix_slot_s;

    logic [CNT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]  wait_cnt_s;
    logic              starve_r;
    logic              starve_s;

    logic              pix_p0_r;
    logic              pix_p1_r;
    logic [7:0]        pix_byte_s;

`ifdef CGA_SNOW_EN
    logic              snow_hit_s;
    logic              snow_wr_p0_r;
    logic              snow_wr_p1_r;
    logic [7:0]        snow_din_p0_r;
    logic [7:0]        snow_din_p1_r;
`endif

    // Upper address bits are ignored: the VRAM aliases across the window.
    logic              unused_addr_hi_s;
    assign unused_addr_hi_s = ^{bus.isa_addr[18:ADDR_W], bus.pixel_addr[18:ADDR_W]};

    assign strb_s  = (bus.isa_read | bus.isa_write) & bus.isa_op_enable;
    assign start_s = strb_s & ~strb_prev_r & (state_r == ISA_IDLE);

    // On the start cycle the live bus is used so the access can be granted at once.
    assign req_addr_s = start_s ? bus.isa_addr[ADDR_W-1:0] : lat_addr_r;
    assign req_din_s  = start_s ? bus.isa_din : lat_din_r;
    assign req_wr_s   = start_s ? bus.isa_write : lat_wr_r;

    assign isa_want_s = start_s | (state_r == ISA_PEND);

    // Wait states only while a strobed access is under way and not yet done.
    assign bus.isa_ready  = ~(strb_s & (state_r != ISA_DONE) &
                              ((state_r != ISA_IDLE) | start_s));
    assign bus.isa_starve = starve_r;

    // Slot decision: which requester owns the VRAM port next cycle.
    always_comb begin
`ifdef CGA_SNOW_EN
        isa_slot_s = isa_want_s;
        pix_slot_s = bus.pixel_req & ~isa_want_s;
        snow_hit_s = bus.pixel_req & isa_want_s;
`else
        isa_slot_s = isa_want_s & ~bus.pixel_req;
        pix_slot_s = bus.pixel_req;
`endif
    end

    // Strobe history; resets high so a strobe held through reset is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            strb_prev_r <= 1'b1;
        end else begin
            strb_prev_r <= strb_s;
        end
    end

    // ISA access state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ISA_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // ISA access next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ISA_IDLE: begin
                if (start_s) begin
                    if (isa_slot_s) begin
                        state_s = req_wr_s ? ISA_DONE : ISA_RD1;
                    end else begin
                        state_s = ISA_PEND;
                    end
                end else begin
                    state_s = ISA_IDLE;
                end
            end
            ISA_PEND: begin
                if (isa_slot_s) begin
                    state_s = req_wr_s ? ISA_DONE : ISA_RD1;
                end else begin
                    state_s = ISA_PEND;
                end
            end
            ISA_RD1: begin
                state_s = ISA_RD2;
            end
            ISA_RD2: begin
                state_s = ISA_DONE;
            end
            ISA_DONE: begin
                if (!strb_s) begin
                    state_s = ISA_IDLE;
                end else begin
                    state_s = ISA_DONE;
                end
            end
            default: begin
                state_s = ISA_IDLE;
            end
        endcase
    end

    // Latch address, data and direction when an access starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr_r <= '0;
            lat_din_r  <= 8'h00;
            lat_wr_r   <= 1'b0;
        end else if (start_s) begin
            lat_addr_r <= bus.isa_addr[ADDR_W-1:0];
            lat_din_r  <= bus.isa_din;
            lat_wr_r   <= bus.isa_write;
        end else begin
            lat_addr_r <= lat_addr_r;
            lat_din_r  <= lat_din_r;
            lat_wr_r   <= lat_wr_r;
        end
    end

    // Saturating wait counter and sticky starvation flag.
    always_comb begin
        wait_cnt_s = wait_cnt_r;
        starve_s   = starve_r;
        if (isa_slot_s) begin
            wait_cnt_s = '0;
        end else if (state_r == ISA_PEND) begin
            if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_s = wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_s = wait_cnt_r;
            end
            if (wait_cnt_s == WAIT_MAX) begin
                starve_s = 1'b1;
            end else begin
                starve_s = starve_r;
            end
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // Wait counter and starvation flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
            starve_r   <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
            starve_r   <= starve_s;
        end
    end

    // Registered VRAM port driven from the slot decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_addr <= '0;
            bus.mem_din  <= 8'h00;
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b0;
        end else if (isa_slot_s) begin
            bus.mem_addr <= req_addr_s;
            bus.mem_din  <= req_din_s;
            bus.mem_we   <= req_wr_s;
            bus.mem_re   <= ~req_wr_s;
        end else if (pix_slot_s) begin
            bus.mem_addr <= bus.pixel_addr[ADDR_W-1:0];
            bus.mem_din  <= bus.mem_din;
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b1;
        end else begin
            bus.mem_addr <= bus.mem_addr;
            bus.mem_din  <= bus.mem_din;
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b0;
        end
    end

    // ISA read data capture, two cycles after the read was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.isa_dout <= 8'h00;
        end else if (state_r == ISA_RD2) begin
            bus.isa_dout <= bus.mem_dout;
        end else begin
            bus.isa_dout <= bus.isa_dout;
        end
    end

`ifdef CGA_SNOW_EN
    // Carry the ISA write byte alongside a displaced pixel fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            snow_wr_p0_r  <= 1'b0;
            snow_wr_p1_r  <= 1'b0;
            snow_din_p0_r <= 8'h00;
            snow_din_p1_r <= 8'h00;
        end else begin
            snow_wr_p0_r  <= snow_hit_s & req_wr_s;
            snow_wr_p1_r  <= snow_wr_p0_r;
            snow_din_p0_r <= req_din_s;
            snow_din_p1_r <= snow_din_p0_r;
        end
    end

    // A displaced write shows its own byte; a displaced read shows mem_dout.
    always_comb begin
        if (snow_wr_p1_r) begin
            pix_byte_s = snow_din_p1_r;
        end else begin
            pix_byte_s = bus.mem_dout;
        end
    end
`else
    // Pixel byte comes straight from the VRAM read port.
    always_comb begin
        pix_byte_s = bus.mem_dout;
    end
`endif

    // Fixed-latency pixel pipeline: request, mem_re, mem_dout, pixel_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_p0_r        <= 1'b0;
            pix_p1_r        <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_data  <= 8'h00;
        end else begin
            pix_p0_r        <= bus.pixel_req;
            pix_p1_r        <= pix_p0_r;
            bus.pixel_valid <= pix_p1_r;
            if (pix_p1_r) begin
                bus.pixel_data <= pix_byte_s;
            end else begin
                bus.pixel_data <= bus.pixel_data;
            end
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb_cga_vram_arbiter
// Directed bench for cga_vram_arbiter with a behavioural VRAM model
// (synchronous read, data one cycle after mem_re). Expectations for the
// CGA_SNOW_EN build are selected with the same macro.
module tb_cga_vram_arbiter;

    localparam int ADDR_W = 14;

`ifdef CGA_SNOW_EN
    localparam int         CONT_GRANT = 1;
    localparam int         CONT_LOW   = 3;
    localparam logic [7:0] CONT_PIX   = 8'h4A;
    localparam int         STV_GRANT  = 1;
    localparam logic       STV_EXP    = 1'b0;
`else
    localparam int         CONT_GRANT = 6;
    localparam int         CONT_LOW   = 8;
    localparam logic [7:0] CONT_PIX   = 8'h7A;
    localparam int         STV_GRANT  = 21;
    localparam logic       STV_EXP    = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       init_mem;
    logic [7:0] vram [0:(1<<ADDR_W)-1];
    int         n_checks = 0;
    int         n_errors = 0;

    cga_vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    cga_vram_arbiter #(.ADDR_W(ADDR_W), .MAX_ISA_WAIT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // VRAM model: preload addr^0x5A, synchronous write and read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < (1<<ADDR_W); i++) vram[i] <= 8'(i) ^ 8'h5A;
            bus.mem_dout <= 8'h00;
        end else begin
            if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_din;
            if (bus.mem_re) bus.mem_dout <= vram[bus.mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_isa(input logic rd, input logic wr, input logic [18:0] a, input logic [7:0] d);
        bus.isa_read      = rd;
        bus.isa_write     = wr;
        bus.isa_op_enable = rd | wr;
        bus.isa_addr      = a;
        bus.isa_din       = d;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int low;
        int bad;
        int acc;

        reset = 1'b1;
        init_mem = 1'b1;
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        bus.pixel_req  = 1'b0;
        bus.pixel_addr = 19'h0;
        to_next();
        init_mem = 1'b0;
        to_next();

        // Reset values
        @(negedge clk);
        check_val("rst_mem_we", bus.mem_we, 1'b0);
        check_val("rst_mem_re", bus.mem_re, 1'b0);
        check_val("rst_mem_addr", bus.mem_addr, 14'h0);
        check_val("rst_pix_valid", bus.pixel_valid, 1'b0);
        check_val("rst_isa_ready", bus.isa_ready, 1'b1);
        check_val("rst_isa_starve", bus.isa_starve, 1'b0);
        check_val("rst_isa_dout", bus.isa_dout, 8'h00);
        to_next();
        reset = 1'b0;

        // Read without address decode hit must not start an access
        bus.isa_read = 1'b1;
        @(negedge clk);
        check_val("noen_ready", bus.isa_ready, 1'b1);
        to_next();
        bus.isa_read = 1'b0;
        @(negedge clk);
        check_val("noen_mem_re", bus.mem_re, 1'b0);
        to_next();

        // Pixel stream, back to back
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.pixel_req  = (k < 16);
            bus.pixel_addr = 19'(k);
            @(negedge clk);
            if (!bus.isa_ready) bad++;
            if (k == 1) check_val("pix_mem_re", bus.mem_re, 1'b1);
            check_val("pix_valid", bus.pixel_valid, (k >= 3 && k <= 18));
            if (k >= 3 && k <= 18) check_val("pix_data", bus.pixel_data, 32'((k - 3) ^ 8'h5A));
            to_next();
        end
        check_val("pix_isa_ready", bad, 0);

        // ISA write 0xA5 to 0x01234
        drive_isa(1'b0, 1'b1, 19'h01234, 8'hA5);
        @(negedge clk);
        check_val("wr_ready_start", bus.isa_ready, 1'b0);
        to_next();
        @(negedge clk);
        check_val("wr_mem_we", bus.mem_we, 1'b1);
        check_val("wr_mem_addr", bus.mem_addr, 14'h1234);
        check_val("wr_mem_din", bus.mem_din, 8'hA5);
        check_val("wr_ready_done", bus.isa_ready, 1'b1);
        to_next();
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        @(negedge clk);
        check_val("wr_mem_we_off", bus.mem_we, 1'b0);
        to_next();

        // ISA read back through an aliased address
        drive_isa(1'b1, 1'b0, 19'h7D234, 8'h00);
        low = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!bus.isa_ready) low++;
            if (k == 1) begin
                check_val("rd_mem_re", bus.mem_re, 1'b1);
                check_val("rd_mem_addr", bus.mem_addr, 14'h1234);
            end
            if (k == 5) check_val("rd_dout", bus.isa_dout, 8'hA5);
            to_next();
        end
        check_val("rd_ready_low", low, 3);
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        to_next();

        // Contention: strobe edge with pixel_req held 5 cycles
        drive_isa(1'b1, 1'b0, 19'h00010, 8'h00);
        low = 0;
        for (int k = 0; k < 12; k++) begin
            bus.pixel_req  = (k < 5);
            bus.pixel_addr = 19'(32 + k);
            @(negedge clk);
            if (!bus.isa_ready) low++;
            if (k == 5) check_val("cont_pix_addr", bus.mem_addr, 14'h0024);
            if (k == CONT_GRANT) begin
                check_val("cont_grant_re", bus.mem_re, 1'b1);
                check_val("cont_grant_addr", bus.mem_addr, 14'h0010);
            end
            if (k == 3) check_val("cont_first_pix", bus.pixel_data, CONT_PIX);
            if (k == 11) check_val("cont_dout", bus.isa_dout, 8'h4A);
            to_next();
        end
        check_val("cont_ready_low", low, CONT_LOW);
        check_val("cont_starve", bus.isa_starve, 1'b0);
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        to_next();

        // Starvation: write pending under 20 cycles of pixel requests
        drive_isa(1'b0, 1'b1, 19'h00300, 8'h3C);
        for (int k = 0; k < 23; k++) begin
            bus.pixel_req  = (k < 20);
            bus.pixel_addr = 19'h0;
            @(negedge clk);
            if (k == 16) check_val("stv_before", bus.isa_starve, 1'b0);
            if (k == 17) check_val("stv_set", bus.isa_starve, STV_EXP);
            if (k == STV_GRANT) begin
                check_val("stv_mem_we", bus.mem_we, 1'b1);
                check_val("stv_mem_addr", bus.mem_addr, 14'h0300);
            end
            if (k == 22) begin
                check_val("stv_ready", bus.isa_ready, 1'b1);
                check_val("stv_sticky", bus.isa_starve, STV_EXP);
            end
            to_next();
        end
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        to_next();
        @(negedge clk);
        check_val("stv_after_strb", bus.isa_starve, STV_EXP);
        to_next();
        reset = 1'b1;
        to_next();
        reset = 1'b0;
        @(negedge clk);
        check_val("stv_cleared", bus.isa_starve, 1'b0);
        to_next();

        // Reset one cycle after a read grant, strobe held
        drive_isa(1'b1, 1'b0, 19'h01234, 8'h00);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            reset = (k == 2);
            @(negedge clk);
            if (k == 1) check_val("mid_mem_re", bus.mem_re, 1'b1);
            if (k == 3) begin
                check_val("mid_dout", bus.isa_dout, 8'h00);
                check_val("mid_ready", bus.isa_ready, 1'b1);
            end
            if (k >= 3) begin
                if (!bus.isa_ready) bad++;
                if (bus.mem_re || bus.mem_we) bad++;
            end
            to_next();
        end
        reset = 1'b0;
        check_val("mid_no_access", bad, 0);
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        to_next();

        // Fresh strobe edge, then strobe held 10 cycles after done
        drive_isa(1'b1, 1'b0, 19'h01234, 8'h00);
        low = 0;
        bad = 0;
        acc = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (!bus.isa_ready) low++;
            if (bus.mem_re || bus.mem_we) acc++;
            if (j == 3) check_val("hold_dout", bus.isa_dout, 8'hA5);
            if (j >= 3) begin
                if (bus.isa_dout !== 8'hA5) bad++;
                if (!bus.isa_ready) bad++;
            end
            to_next();
        end
        check_val("hold_ready_low", low, 3);
        check_val("hold_accesses", acc, 1);
        check_val("hold_stable", bad, 0);
        drive_isa(1'b0, 1'b0, 19'h0, 8'h00);
        @(negedge clk);
        check_val("hold_release_ready", bus.isa_ready, 1'b1);
        to_next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
